// File: rtl/snap_pkg.sv
// Shared types and helpers for the snapshot capture engine: capture FSM
// states, capture-length clamping and lane-select width calculation.
package snap_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } snap_state_e;

   // A length of zero or anything beyond the RAM depth means "fill the RAM".
   function automatic int unsigned clamp_len(input int unsigned len_v,
                                             input int unsigned depth);
      if (len_v == 0 || len_v > depth) return depth;
      return len_v;
   endfunction

   // Lane-select bits on the CPU address; a single lane still gets one bit.
   function automatic int calc_ch_w(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

endpackage

// File: rtl/snap_bram_capture_if.sv
// CPU read bus of the snapshot engine: address is {lane, word}, data comes
// back two cycles later and holds while cpu_en is low.
interface snap_bram_capture_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int CH_W   = 1
);
   logic                     cpu_en;
   logic [CH_W+ADDR_W-1:0]   cpu_addr;
   logic [DATA_W-1:0]        cpu_rd_data;

   modport master (output cpu_en, cpu_addr, input cpu_rd_data);
   modport slave  (input cpu_en, cpu_addr, output cpu_rd_data);
endinterface

// File: rtl/snap_dpram.sv
// One lane of capture storage: simple dual-port RAM, one write port from the
// capture side, one read port for the CPU with a 2-cycle registered read.
// Read-first on a same-address collision; contents are never cleared.
module snap_dpram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic              re_q, re_d;
   logic [DATA_W-1:0] out_q, out_d;

   // RAM array plus its primitive read register; no reset so it maps to BRAM
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) ram_q <= mem[raddr];
   end

   // Second stage only advances behind a real read, so data holds otherwise
   always_comb begin
      re_d  = re;
      out_d = out_q;
      if (re_q) out_d = ram_q;
   end

   // Output register, reset to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         re_q  <= 1'b0;
         out_q <= '0;
      end else begin
         re_q  <= re_d;
         out_q <= out_d;
      end
   end

   assign rdata = out_q;

endmodule

// File: rtl/snap_bram_capture.sv
// Multi-lane snapshot capture engine: arm/trigger FSM, programmable capture
// length, NCH parallel RAM lanes readable from the CPU bus.
// Optional build macro SNAP_CIRC_PRETRIG_EN: while armed, every valid sample
// is written circularly so a window of pre-trigger history is kept.
module snap_bram_capture
   import snap_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int NCH    = 1,
   parameter int CH_W   = calc_ch_w(NCH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*DATA_W-1:0] din,
   input  logic                  din_valid,
   input  logic                  arm,
   input  logic                  trig,
   input  logic [ADDR_W:0]       len,
   input  logic [ADDR_W-1:0]     pretrig,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     start_addr,
   output logic [ADDR_W:0]       count,
   snap_bram_capture_if.slave    cpu
);
   localparam int unsigned  DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   snap_state_e       state_q, state_d;
   logic              arm_q, arm_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic              arm_edge;
   logic [ADDR_W:0]   len_in_eff;
   logic [ADDR_W:0]   base;
   logic              we;
   logic              ram_we;

`ifdef SNAP_CIRC_PRETRIG_EN
   logic [ADDR_W-1:0] pretrig_q, pretrig_d;
   logic [ADDR_W:0]   armed_cnt_q, armed_cnt_d;
   logic [ADDR_W:0]   pre_eff;
`else
   logic              unused_pretrig;
   assign unused_pretrig = ^pretrig;
`endif

   assign arm_edge   = arm & ~arm_q;
   assign len_in_eff = (ADDR_W+1)'(clamp_len(32'(len), DEPTH));

`ifdef SNAP_CIRC_PRETRIG_EN
   // History actually available: never more than what was written since arm
   assign pre_eff = ({1'b0, pretrig_q} <= armed_cnt_q) ? {1'b0, pretrig_q} : armed_cnt_q;
`endif

   // Capture FSM, write pointer and sample counter
   always_comb begin
      state_d  = state_q;
      arm_d    = arm;
      len_d    = len_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      start_d  = start_q;
      base     = '0;
      we       = 1'b0;
`ifdef SNAP_CIRC_PRETRIG_EN
      pretrig_d   = pretrig_q;
      armed_cnt_d = armed_cnt_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm_edge) begin
               state_d  = S_ARMED;
               len_d    = len_in_eff;
               count_d  = '0;
               wr_ptr_d = '0;
               start_d  = '0;
`ifdef SNAP_CIRC_PRETRIG_EN
               // Keep at least one post-trigger sample in the window
               pretrig_d   = ({1'b0, pretrig} >= len_in_eff) ?
                             ADDR_W'(len_in_eff - (ADDR_W+1)'(1)) : pretrig;
               armed_cnt_d = '0;
`endif
            end
         end
         S_ARMED: begin
`ifdef SNAP_CIRC_PRETRIG_EN
            we = din_valid;
            if (din_valid && armed_cnt_q != DEPTH_L)
               armed_cnt_d = armed_cnt_q + (ADDR_W+1)'(1);
`endif
            if (trig) begin
`ifdef SNAP_CIRC_PRETRIG_EN
               base    = pre_eff;
               start_d = wr_ptr_q - pre_eff[ADDR_W-1:0];
`endif
               // The trigger cycle's own sample is part of the capture
               we      = din_valid;
               count_d = base + (ADDR_W+1)'(din_valid);
               state_d = (din_valid && (base + (ADDR_W+1)'(1)) >= len_q) ? S_DONE : S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (din_valid) begin
               we      = 1'b1;
               count_d = count_q + (ADDR_W+1)'(1);
               if ((count_q + (ADDR_W+1)'(1)) >= len_q) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (we) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
   end

   // Control state registers; reset returns to IDLE without touching RAM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         arm_q    <= 1'b0;
         len_q    <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         start_q  <= '0;
`ifdef SNAP_CIRC_PRETRIG_EN
         pretrig_q   <= '0;
         armed_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         arm_q    <= arm_d;
         len_q    <= len_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         start_q  <= start_d;
`ifdef SNAP_CIRC_PRETRIG_EN
         pretrig_q   <= pretrig_d;
         armed_cnt_q <= armed_cnt_d;
`endif
      end
   end

   // Reset must win over a write presented in the same cycle
   assign ram_we = we & ~rst;

   assign busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign done       = (state_q == S_DONE);
   assign start_addr = start_q;
   assign count      = count_q;

   // ---------------- RAM lanes and CPU read path ----------------
   logic [NCH-1:0][DATA_W-1:0] lane_rd;
   logic [CH_W-1:0]            cpu_lane;
   logic [CH_W-1:0]            sel1_q, sel1_d, sel2_q, sel2_d;
   logic                       oob1_q, oob1_d, oob2_q, oob2_d;
   logic                       rd_vld_q, rd_vld_d;
   logic [DATA_W-1:0]          rd_mux;

   assign cpu_lane = cpu.cpu_addr[CH_W+ADDR_W-1:ADDR_W];

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      snap_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
         .clk   (clk),
         .rst   (rst),
         .we    (ram_we),
         .waddr (wr_ptr_q),
         .wdata (din[k*DATA_W +: DATA_W]),
         .re    (cpu.cpu_en),
         .raddr (cpu.cpu_addr[ADDR_W-1:0]),
         .rdata (lane_rd[k])
      );
   end

   // Lane select follows the read through both RAM stages
   always_comb begin
      rd_vld_d = cpu.cpu_en;
      sel1_d   = sel1_q;
      oob1_d   = oob1_q;
      sel2_d   = sel2_q;
      oob2_d   = oob2_q;
      if (cpu.cpu_en) begin
         sel1_d = cpu_lane;
         oob1_d = ({1'b0, cpu_lane} >= (CH_W+1)'(NCH));
      end
      if (rd_vld_q) begin
         sel2_d = sel1_q;
         oob2_d = oob1_q;
      end
   end

   // Lane-select pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
         sel1_q   <= '0;
         oob1_q   <= 1'b0;
         sel2_q   <= '0;
         oob2_q   <= 1'b0;
      end else begin
         rd_vld_q <= rd_vld_d;
         sel1_q   <= sel1_d;
         oob1_q   <= oob1_d;
         sel2_q   <= sel2_d;
         oob2_q   <= oob2_d;
      end
   end

   // Output mux; a nonexistent lane reads as zero
   always_comb begin
      rd_mux = '0;
      if (!oob2_q) begin
         for (int k = 0; k < NCH; k++)
            if (sel2_q == CH_W'(k)) rd_mux = lane_rd[k];
      end
   end

   assign cpu.cpu_rd_data = rd_mux;

endmodule
